// File: rtl/down_count_timer_if.sv
// down_count_timer_if: control/status bundle for the down-counting timer; overrun exists only with DOWN_COUNT_TIMER_OVERRUN_EN.
interface down_count_timer_if #(parameter int WIDTH = 3);
  logic enable, start, auto_reload, ack;
  logic [WIDTH-1:0] load_val, out;
  logic busy, tc, done;
`ifdef DOWN_COUNT_TIMER_OVERRUN_EN
  logic overrun;
  modport master(output enable, start, load_val, auto_reload, ack, input out, busy, tc, done, overrun);
  modport slave(input enable, start, load_val, auto_reload, ack, output out, busy, tc, done, overrun);
`else
  modport master(output enable, start, load_val, auto_reload, ack, input out, busy, tc, done);
  modport slave(input enable, start, load_val, auto_reload, ack, output out, busy, tc, done);
`endif
endinterface

// File: rtl/down_count_timer.sv
// down_count_timer: loadable falling-edge down counter with tc pulse, sticky done or auto-reload.
// Optional DOWN_COUNT_TIMER_OVERRUN_EN adds an overrun flag for unacknowledged terminal counts.
module down_count_timer #(parameter int WIDTH = 3) (
  input logic clk,
  input logic reset,
  down_count_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] rld;
  logic load, tc_set;
  assign load = bus.start && state != DONE;
  assign tc_set = load ? bus.load_val == '0 : state == RUN && bus.enable && bus.out == WIDTH'(1);
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  // A zero count while in RUN can only mean an auto-reload is due on this edge.
  always_ff @(negedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      bus.out <= '0;
      rld <= '0;
      bus.tc <= 1'b0;
    end else begin
      bus.tc <= tc_set;
      if (load) begin
        bus.out <= bus.load_val;
        rld <= bus.load_val;
        state <= bus.load_val == '0 ? DONE : RUN;
      end else if (state == RUN && bus.out == '0)
        bus.out <= rld;
      else if (state == RUN && bus.enable) begin
        bus.out <= bus.out - 1'b1;
        if (bus.out == WIDTH'(1) && !bus.auto_reload) state <= DONE;
      end else if (state == DONE && bus.ack)
        state <= IDLE;
    end
`ifdef DOWN_COUNT_TIMER_OVERRUN_EN
  logic pending;
  always_ff @(negedge clk or negedge reset)
    if (!reset) begin
      pending <= 1'b0;
      bus.overrun <= 1'b0;
    end else if (tc_set) begin
      pending <= 1'b1;
      if (pending && !bus.ack) bus.overrun <= 1'b1;
    end else if (bus.ack) begin
      pending <= 1'b0;
      bus.overrun <= 1'b0;
    end
`endif
endmodule

// File: doc/down_count_timer.md
# down_count_timer

Loadable down-counting interval timer, the counting complement of the team's free-running mod-8 up counter. Software or a controller FSM loads a start value, and the block counts down on qualified clock edges to zero. At zero it raises a terminal-count pulse and then either holds a sticky `done` until acknowledged or reloads automatically. It sits next to the up counter in the timing/sequencing subsystem and shares its clocking and reset style.

## Interface
Parameters:
- `WIDTH`, 3: counter width; the count range is 0 to 2^WIDTH−1 (mod-8 at default).

Ports:
- `clk`  in  1  clock; all state updates on the falling edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  count qualifier; decrement occurs only on edges where it is high.
- `start`  in  1  load `load_val` and begin counting.
- `load_val`  in  WIDTH  start/reload value, sampled only when `start` is accepted.
- `auto_reload`  in  1  at terminal count, reload and continue instead of stopping.
- `ack`  in  1  clears `done`; returns to IDLE.
- `out`  out  WIDTH  current count.
- `busy`  out  1  high in RUN.
- `tc`  out  1  one-cycle terminal-count pulse.
- `done`  out  1  high in DONE, held until `ack`.
- `overrun`  out  1  present only with `DOWN_COUNT_TIMER_OVERRUN_EN`.

## Operation
- Internal reload register `rld` (WIDTH bits) captures `load_val` when `start` is accepted.
- FSM states are IDLE, RUN and DONE. `out` is registered. `busy`/`done` decode from state. `tc` is registered.
- IDLE:
  - `out` holds.
  - On `start` with `load_val`≠0: `out`←`load_val`, `rld`←`load_val`, go to RUN.
  - On `start` with `load_val`=0: `out`←0, `tc`←1, go to DONE. This is one-shot regardless of `auto_reload`.
- RUN, `enable` low: `out` frozen, state held.
- RUN, `enable` high, `out`>1: `out`←`out`−1.
- RUN, `enable` high, `out`=1: `out`←0, `tc`←1.
  - If `auto_reload`=0, go to DONE.
  - If `auto_reload`=1, the next edge loads `out`←`rld` and stays in RUN. The zero value is visible for exactly one cycle, and that reload edge ignores `enable`.
- RUN, `start`: restarts. `out`←`load_val`, `rld`←`load_val`, state stays RUN (or goes to DONE if `load_val`=0, with `tc` pulse). `start` takes priority over decrement.
- DONE:
  - `out` holds 0.
  - `ack` moves to IDLE.
  - `start` is ignored in DONE, including when it arrives in the same cycle as `ack`.
- `ack` outside DONE has no effect, except as described for `overrun`.
- No wrap-around: the counter never decrements below 0.
- Arithmetic is unsigned, modulo 2^WIDTH. Decrement is applied only when `out`≥1.

## Timing
- Reset (`reset`=0, asynchronous) sets: state IDLE, `out`=0, `rld`=0, `busy`=0, `tc`=0, `done`=0, `overrun`=0. The reset takes effect immediately, with no clock needed.
- Reset asserted mid-RUN aborts the count. After release, the block waits in IDLE for `start`.
- Start latency is 1 edge: `start` sampled at edge k gives `out`=`load_val` and `busy`=1 after edge k.
- For `load_val`=N with `enable` held high: `out`=0 and `tc`=1 after edge k+N. `done`=1 after that same edge when `auto_reload`=0.
- `tc` is high for exactly one clock period per terminal count.
- `ack` sampled at edge m gives `done`=0 after edge m.
- `auto_reload` is sampled on the edge where `out` goes 1→0.

## Configuration
- Macro: `DOWN_COUNT_TIMER_OVERRUN_EN`.
- Defined:
  - Adds a `overrun` output and an internal `pending` flag.
  - `pending` sets on every `tc` and clears on `ack`.
  - If `tc` fires while `pending` is already set (auto-reload period not acknowledged), `overrun` sets.
  - `overrun` is sticky until `ack` or reset.
  - When `tc` and `ack` occur on the same edge, `pending` stays set and `overrun` is unchanged.
- Undefined: no `overrun` port and no `pending` logic. `ack` affects only DONE→IDLE.

## Test plan
- Reset mid-count: `start`, `load_val`=6, 3 enabled edges (`out`=3), pulse `reset` low between edges -> `out`=0, `busy`=0 immediately; stays IDLE after release.
- One-shot: `load_val`=5, `enable`=1 -> `out` sequence 5,4,3,2,1,0. `tc`=1 for one cycle at 0. `done`=1 and holds until `ack`, then IDLE with `out`=0.
- Enable gating: `load_val`=3, `enable` toggled 1,0,0,1,1 -> `out` 3,2,2,2,1,0. `tc` fires only on the final edge.
- Auto-reload: `load_val`=2, `auto_reload`=1 -> `out` 2,1,0,2,1,0,… with a `tc` pulse at each 0 and `done` never asserted.
- Boundaries:
  - `start` with `load_val`=0 -> immediate `tc` and DONE.
  - `start` with `load_val`=7 in RUN at `out`=4 -> `out`=7.
  - `start` together with `ack` in DONE -> IDLE, `out`=0, no load.
- With `DOWN_COUNT_TIMER_OVERRUN_EN`: auto-reload `load_val`=1, no `ack` -> `overrun`=1 at the 2nd `tc`. `ack` clears it. With `ack` after each `tc`, `overrun` stays 0.
